// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared constants and types for the playfield row logic.
//   CW          : bits per cell code
//   COLS        : cells per row
//   NUM_COLORS  : number of block colours, encoded 1..NUM_COLORS, 0 = empty
//   cell_t      : one cell code
//   row_t       : one packed row, cell c at [CW*c+CW-1:CW*c]
//   state_t     : new_row_gen FSM encoding
// Helpers: next_color (colour wrap-around), cell_at (safe cell select).
// -----------------------------------------------------------------------------
package tetris_pkg;

  localparam int CW         = 3;
  localparam int COLS       = 6;
  localparam int NUM_COLORS = 5;
  localparam int COL_W      = 3;
  localparam int SEED_W     = 50;

  typedef logic [CW-1:0]    cell_t;
  typedef cell_t [COLS-1:0] row_t;

  localparam cell_t COLOR_EMPTY = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Next colour in the 1..NUM_COLORS cycle, wrapping back to 1.
  function automatic cell_t next_color(input cell_t c);
    return (c == cell_t'(NUM_COLORS)) ? 3'd1 : (c + 3'd1);
  endfunction

  // Cell select that yields COLOR_EMPTY for indices beyond the row.
  function automatic cell_t cell_at(input row_t r, input logic [COL_W-1:0] idx);
    cell_t res;
    res = COLOR_EMPTY;
    for (int c = 0; c < COLS; c++) begin
      res = (idx == COL_W'(c)) ? r[c] : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/row_cell_check.sv
// -----------------------------------------------------------------------------
// row_cell_check
// Combinational legality check for one candidate colour.
//   cand      : candidate colour for the current column
//   left1     : colour already placed one column to the left
//   left2     : colour already placed two columns to the left
//   above     : colour of the cell directly above (0 = empty)
//   col_ge2   : current column index is 2 or more
//   conflict  : candidate is illegal
//   next_cand : colour to try next if it is illegal
// -----------------------------------------------------------------------------
module row_cell_check
  import tetris_pkg::*;
(
  input  cell_t cand,
  input  cell_t left1,
  input  cell_t left2,
  input  cell_t above,
  input  logic  col_ge2,
  output logic  conflict,
  output cell_t next_cand
);

  logic above_hit_s;
  logic triple_hit_s;

  // Flag a vertical match or a horizontal triple and offer the next colour.
  always_comb begin
    above_hit_s  = 1'b0;
    triple_hit_s = 1'b0;
    if (above != COLOR_EMPTY) begin
      above_hit_s = (cand == above);
    end else begin
      above_hit_s = 1'b0;
    end
    if (col_ge2) begin
      triple_hit_s = (left1 == cand) && (left2 == cand);
    end else begin
      triple_hit_s = 1'b0;
    end
    conflict  = above_hit_s || triple_hit_s;
    next_cand = next_color(cand);
  end

endmodule

// File: rtl/new_row_gen.sv
// -----------------------------------------------------------------------------
// new_row_gen
// Builds the next row rising into the playfield from the PRNG seed, one
// candidate colour per clock, avoiding vertical matches and horizontal triples.
//   Clk        : system clock
//   Reset_n    : asynchronous active-low reset
//   seed       : PRNG state, sampled on an accepted req
//   req        : request a row, accepted only in IDLE
//   above_row  : current bottom board row, sampled with req
//   ack        : consumer has taken the row (while valid)
//   row        : generated row, same packing as above_row
//   valid      : row complete and stable
//   busy       : generation in progress or row awaiting ack
//   retry_cnt  : saturating conflict counter (only with NEW_ROW_GEN_STATS_EN)
// Build option: define NEW_ROW_GEN_STATS_EN to add the retry_cnt output.
// -----------------------------------------------------------------------------
module new_row_gen
  import tetris_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [SEED_W-1:0]    seed,
  input  logic                 req,
  input  logic [COLS*CW-1:0]   above_row,
  input  logic                 ack,
  output logic [COLS*CW-1:0]   row,
  output logic                 valid,
  output logic                 busy
`ifdef NEW_ROW_GEN_STATS_EN
  ,
  output logic [15:0]          retry_cnt
`endif
);

  state_t            state_r, state_s;
  logic [SEED_W-1:0] sreg_r, sreg_s;
  row_t              areg_r, areg_s;
  row_t              row_r, row_s;
  logic [COL_W-1:0]  col_r, col_s;
  cell_t             cand_r, cand_s;
  logic              retry_r, retry_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;

  logic [7:0]        mod_s;
  cell_t             first_cand_s;
  cell_t             cur_cand_s;
  cell_t             above_cell_s;
  cell_t             left1_s;
  cell_t             left2_s;
  logic              col_ge2_s;
  logic              conflict_s;
  cell_t             next_cand_s;

  // Candidate for the current attempt: seed-derived on a column's first try,
  // otherwise the stepped colour kept from the previous conflicting attempt.
  always_comb begin
    mod_s        = sreg_r[7:0] % 8'(NUM_COLORS);
    first_cand_s = cell_t'(mod_s + 8'd1);
    if (retry_r) begin
      cur_cand_s = cand_r;
    end else begin
      cur_cand_s = first_cand_s;
    end
    above_cell_s = cell_at(areg_r, col_r);
    left1_s      = cell_at(row_r, col_r - 3'd1);
    left2_s      = cell_at(row_r, col_r - 3'd2);
    col_ge2_s    = (col_r >= 3'd2);
  end

  row_cell_check u_check (
    .cand      (cur_cand_s),
    .left1     (left1_s),
    .left2     (left2_s),
    .above     (above_cell_s),
    .col_ge2   (col_ge2_s),
    .conflict  (conflict_s),
    .next_cand (next_cand_s)
  );

  // Next-state and next-register values for the row generator FSM.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    areg_s  = areg_r;
    row_s   = row_r;
    col_s   = col_r;
    cand_s  = cand_r;
    retry_s = retry_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          sreg_s  = seed;
          areg_s  = above_row;
          row_s   = {(COLS*CW){1'b0}};
          col_s   = 3'd0;
          retry_s = 1'b0;
          busy_s  = 1'b1;
          state_s = GEN;
        end else begin
          state_s = IDLE;
        end
      end
      GEN: begin
        if (conflict_s) begin
          // Same column, same seed byte: just try the next colour.
          cand_s  = next_cand_s;
          retry_s = 1'b1;
        end else begin
          for (int c = 0; c < COLS; c++) begin
            row_s[c] = (col_r == COL_W'(c)) ? cur_cand_s : row_r[c];
          end
          sreg_s  = {sreg_r[7:0], sreg_r[SEED_W-1:8]};
          retry_s = 1'b0;
          if (col_r == COL_W'(COLS-1)) begin
            valid_s = 1'b1;
            state_s = DONE;
          end else begin
            col_s = col_r + 3'd1;
          end
        end
      end
      DONE: begin
        if (ack) begin
          valid_s = 1'b0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      sreg_r  <= {SEED_W{1'b0}};
      areg_r  <= {(COLS*CW){1'b0}};
      row_r   <= {(COLS*CW){1'b0}};
      col_r   <= 3'd0;
      cand_r  <= COLOR_EMPTY;
      retry_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sreg_r  <= sreg_s;
      areg_r  <= areg_s;
      row_r   <= row_s;
      col_r   <= col_s;
      cand_r  <= cand_s;
      retry_r <= retry_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign row   = row_r;
  assign valid = valid_r;
  assign busy  = busy_r;

`ifdef NEW_ROW_GEN_STATS_EN
  logic [15:0] retry_cnt_r;

  // Saturating count of conflict cycles; only the hard reset clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retry_cnt_r <= 16'd0;
    end else if ((state_r == GEN) && conflict_s && (retry_cnt_r != 16'hFFFF)) begin
      retry_cnt_r <= retry_cnt_r + 16'd1;
    end else begin
      retry_cnt_r <= retry_cnt_r;
    end
  end

  assign retry_cnt = retry_cnt_r;
`endif

endmodule

// File: tb/tb_new_row_gen.sv
// -----------------------------------------------------------------------------
// tb_new_row_gen
// Scoreboard bench for new_row_gen: the driver pushes the expected row and the
// cycle at which valid must rise; a monitor pops and compares on each new row.
// Random rows are predicted by a behavioural model of the colour rules.
// -----------------------------------------------------------------------------
module tb_new_row_gen;

  localparam int NC = 5;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [49:0] seed;
  logic        req;
  logic [17:0] above_row;
  logic        ack;
  logic [17:0] row;
  logic        valid;
  logic        busy;
`ifdef NEW_ROW_GEN_STATS_EN
  logic [15:0] retry_cnt;
`endif

  new_row_gen dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .seed      (seed),
    .req       (req),
    .above_row (above_row),
    .ack       (ack),
    .row       (row),
    .valid     (valid),
    .busy      (busy)
`ifdef NEW_ROW_GEN_STATS_EN
    ,
    .retry_cnt (retry_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [17:0] row;
    int          vcyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   pushed = 0;
  int   popped = 0;
  logic valid_q = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: legal colour choice straight from the rules, counting attempts.
  function automatic void ref_row(input logic [49:0] s_in, input logic [17:0] a,
                                  output logic [17:0] r, output int lat);
    int cells[6];
    logic [49:0] s;
    s   = s_in;
    r   = 18'd0;
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      int above_c;
      int v;
      int guard;
      above_c = int'((a >> (3 * c)) & 18'h7);
      v       = (int'(s[7:0]) % NC) + 1;
      guard   = 0;
      lat++;
      while (guard < 10 &&
             ((above_c != 0 && v == above_c) ||
              (c >= 2 && cells[c-1] == v && cells[c-2] == v))) begin
        v = (v == NC) ? 1 : v + 1;
        lat++;
        guard++;
      end
      cells[c] = v;
      r = r | (18'(v) << (3 * c));
      s = {s[7:0], s[49:8]};
    end
  endfunction

  // Monitor: each rising valid must match the oldest scoreboard entry.
  always @(negedge Clk) begin
    exp_t e;
    if (valid === 1'b1 && valid_q !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got row %0h with empty scoreboard", row);
      end else begin
        e = sb_q.pop_front();
        popped++;
        check("row", 32'(row), 32'(e.row));
        check("valid_cycle", 32'(cyc), 32'(e.vcyc));
      end
    end
    valid_q = valid;
  end

  // One complete request / generate / hold / ack transaction.
  task automatic do_row(input logic [49:0] s, input logic [17:0] a,
                        input logic [17:0] er, input int el, input int hold);
    int n;
    @(negedge Clk);
    seed      = s;
    above_row = a;
    req       = 1'b1;
    @(negedge Clk);
    req       = 1'b0;
    seed      = {$urandom, $urandom};
    above_row = 18'($urandom);
    sb_q.push_back('{row: er, vcyc: cyc + el});
    pushed++;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      check("busy_gen", 32'(busy), 32'd1);
      @(negedge Clk);
      n++;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got valid=%b expected 1 within 40 cycles", valid);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_row", 32'(row), 32'(er));
      check("hold_busy", 32'(busy), 32'd1);
      req  = (i == hold / 2) ? 1'b1 : 1'b0;
      seed = {$urandom, $urandom};
      @(negedge Clk);
    end
    req  = 1'b0;
    check("done_ignores_req", 32'(row), 32'(er));
    ack  = 1'b1;
    req  = 1'b1;
    @(negedge Clk);
    ack  = 1'b0;
    req  = 1'b0;
    check("ack_valid", 32'(valid), 32'd0);
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_row_kept", 32'(row), 32'(er));
    @(negedge Clk);
    check("idle_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [17:0] er;
    logic [17:0] a;
    logic [49:0] s;
    int          el;

    Reset_n   = 1'b0;
    seed      = 50'd0;
    req       = 1'b0;
    above_row = 18'd0;
    ack       = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_row", 32'(row), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
`ifdef NEW_ROW_GEN_STATS_EN
    check("reset_retry_cnt", 32'(retry_cnt), 32'd0);
`endif
    Reset_n = 1'b1;

    // Directed rows with hand-derived results.
    do_row(50'h66, 18'h00000, 18'h0944B, 7, 10);
    do_row(50'h66, 18'h1B6DB, 18'h0944C, 8, 4);
`ifdef NEW_ROW_GEN_STATS_EN
    check("retry_cnt", 32'(retry_cnt), 32'd3);
`endif
    do_row(50'h04, 18'h00005, 18'h11289, 9, 3);

    // Reset asserted mid-generation (column 3) must clear at once.
    @(negedge Clk);
    seed      = 50'h66;
    above_row = 18'd0;
    req       = 1'b1;
    @(negedge Clk);
    req = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_row", 32'(row), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    do_row(50'h66, 18'h00000, 18'h0944B, 7, 3);

    // Randomized rows against the reference model.
    for (int k = 0; k < 30; k++) begin
      s = {$urandom, $urandom};
      a = 18'd0;
      for (int c = 0; c < 6; c++) begin
        a = a | (18'($urandom_range(0, NC)) << (3 * c));
      end
      ref_row(s, a, er, el);
      do_row(s, a, er, el, $urandom_range(3, 6));
    end

    repeat (2) @(negedge Clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("rows_seen", 32'(popped), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
